seq_alu: RTL

- Clocked, parametrised successor of the combinational 4-bit ALU that drives the lab board displays.
- Adds registered results and flags, a start/busy/done handshake, and the previously missing division and modulo operations.
- Division and modulo use an N-cycle restoring divider.
- Sits between the switch/button input logic and the seven-segment display drivers; displays are driven from the registered result.

---
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Operand, control and result bundle between the switch/button logic and seq_alu.
// The master drives the request side; the slave (the ALU) returns results and flags.
interface seq_alu_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] firstNum;
  logic [N-1:0] secNum;
  logic [1:0]   operation;
  logic [N-1:0] result;
  logic [6:0]   resultSegment;
  logic         busy;
  logic         done;
  logic         carry;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         divZero;

  modport master (
    output start, firstNum, secNum, operation,
    input  result, resultSegment, busy, done, carry, negative, zero, overflow, divZero
  );

  modport slave (
    input  start, firstNum, secNum, operation,
    output result, resultSegment, busy, done, carry, negative, zero, overflow, divZero
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential N-bit ALU: single-edge add/sub, N-cycle restoring divide/modulo,
// registered result and flags, and a seven-segment decode of the low result nibble.
module seq_alu #(
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  localparam logic [1:0]   OP_ADD = 2'b00;
  localparam logic [1:0]   OP_SUB = 2'b01;
  localparam logic [1:0]   OP_DIV = 2'b10;
  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] LAST_STEP = N[N-1:0] - ONE;

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] divisor_q, divisor_d;
  logic [N-1:0] quo_q, quo_d;
  logic [N-1:0] rem_q, rem_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] result_q, result_d;
  logic         carry_q, carry_d;
  logic         negative_q, negative_d;
  logic         zero_q, zero_d;
  logic         overflow_q, overflow_d;
  logic         div_zero_q, div_zero_d;

  logic [N:0]   sum, diff, shifted, trial;
  logic [N-1:0] rem_step, quo_step;
  logic         trial_ok;
  logic         wr_en, wr_carry, wr_ovf, wr_dz;
  logic [N-1:0] wr_result;
  logic [N-1:0] a, b;

  assign a    = bus.firstNum;
  assign b    = bus.secNum;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Restoring step: shift the next dividend bit into the partial remainder and
  // keep the subtraction only when it does not go negative.
  assign shifted  = {rem_q, quo_q[N-1]};
  assign trial    = shifted - {1'b0, divisor_q};
  assign trial_ok = ~trial[N];
  assign rem_step = trial_ok ? trial[N-1:0] : shifted[N-1:0];
  assign quo_step = {quo_q[N-2:0], trial_ok};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    divisor_d  = divisor_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    result_d   = result_q;
    carry_d    = carry_q;
    negative_d = negative_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    div_zero_d = div_zero_q;
    wr_en      = 1'b0;
    wr_result  = '0;
    wr_carry   = 1'b0;
    wr_ovf     = 1'b0;
    wr_dz      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d = bus.operation;
          if (bus.operation == OP_ADD) begin
            wr_en     = 1'b1;
            wr_result = sum[N-1:0];
            wr_carry  = sum[N];
            wr_ovf    = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
          end else if (bus.operation == OP_SUB) begin
            wr_en     = 1'b1;
            wr_result = diff[N-1:0];
            wr_carry  = diff[N];
            wr_ovf    = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
          end else if (b == '0) begin
            wr_en     = 1'b1;
            wr_result = (bus.operation == OP_DIV) ? '1 : a;
            wr_dz     = 1'b1;
          end else begin
            divisor_d = b;
            quo_d     = a;
            rem_d     = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST_STEP) begin
          wr_en     = 1'b1;
          wr_result = (op_q == OP_DIV) ? quo_step : rem_step;
          busy_d    = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every completed operation updates result and all flags together.
    if (wr_en) begin
      state_d    = DONE;
      result_d   = wr_result;
      carry_d    = wr_carry;
      overflow_d = wr_ovf;
      div_zero_d = wr_dz;
      negative_d = wr_result[N-1];
      zero_d     = (wr_result == '0);
    end
    done_d = wr_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      divisor_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      divisor_q  <= divisor_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      negative_q <= negative_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Narrow configurations show the result zero-extended on the display.
  logic [3:0] nibble;
  generate
    if (N >= 4) begin : g_nib_wide
      assign nibble = result_q[3:0];
    end else begin : g_nib_narrow
      assign nibble = {{(4-N){1'b0}}, result_q};
    end
  endgenerate

  logic [6:0] segment;
  always_comb begin
    segment = 7'b1111111;
    unique case (nibble)
      4'h0: segment = 7'b1000000;
      4'h1: segment = 7'b1111001;
      4'h2: segment = 7'b0100100;
      4'h3: segment = 7'b0110000;
      4'h4: segment = 7'b0011001;
      4'h5: segment = 7'b0010010;
      4'h6: segment = 7'b0000010;
      4'h7: segment = 7'b1111000;
      4'h8: segment = 7'b0000000;
      4'h9: segment = 7'b0010000;
      4'hA: segment = 7'b0001000;
      4'hB: segment = 7'b0000011;
      4'hC: segment = 7'b1000110;
      4'hD: segment = 7'b0100001;
      4'hE: segment = 7'b0000110;
      4'hF: segment = 7'b0001110;
      default: segment = 7'b1111111;
    endcase
  end

  assign bus.result        = result_q;
  assign bus.resultSegment = segment;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.carry         = carry_q;
  assign bus.negative      = negative_q;
  assign bus.zero          = zero_q;
  assign bus.overflow      = overflow_q;
  assign bus.divZero       = div_zero_q;
endmodule
